// File: rtl/sdpram_stream_reader.sv
// Read-side master for a simple dual-port RAM (port B): turns (addr, len) commands into
// sequential 1-cycle-latency reads and streams the words out on a valid/ready interface.
module sdpram_stream_reader #(
   parameter int AW   = 10,
   parameter int DW   = 32,
   parameter int LENW = 11
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [AW-1:0]   cmd_addr,
   input  logic [LENW-1:0] cmd_len,
   output logic            renb,
   output logic [AW-1:0]   addrb,
   input  logic [DW-1:0]   doutb,
   output logic            m_valid,
   input  logic            m_ready,
   output logic [DW-1:0]   m_data,
   output logic            m_last,
   output logic            busy,
   output logic            done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ  = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t          state_reg, state_next;
   logic [AW-1:0]   addr_reg, addr_next;
   logic [LENW-1:0] remaining_reg, remaining_next;
   logic            done_reg, done_next;
   logic            inflight_reg, inflight_last_reg;
   logic [1:0]      count_reg, count_next;
   logic            wr_ptr_reg, rd_ptr_reg;

   logic            push, pop, issue, issue_last, credit_ok;
   logic [2:0]      occupancy;
   logic [DW-1:0]   head_data [2];
   logic            head_last [2];

   // Occupancy counts the FIFO plus the read still inside the RAM; a beat leaving
   // this cycle frees a slot, which is the only m_ready-to-renb path.
   assign occupancy  = {1'b0, count_reg} + {2'b00, inflight_reg};
   assign credit_ok  = occupancy < (3'd2 + {2'b00, pop});
   assign issue      = (state_reg == READ) && (remaining_reg != '0) && credit_ok;
   assign issue_last = issue && (remaining_reg == LENW'(1));

   assign push       = inflight_reg;
   assign m_valid    = (count_reg != 2'd0);
   assign pop        = m_valid && m_ready;
   assign count_next = count_reg + {1'b0, push} - {1'b0, pop};

   assign renb       = issue;
   assign addrb      = addr_reg;
   assign cmd_ready  = (state_reg == IDLE);
   assign busy       = (state_reg != IDLE);
   assign done       = done_reg;
   assign m_data     = head_data[rd_ptr_reg];
   assign m_last     = m_valid && head_last[rd_ptr_reg];

   always_comb begin
      state_next     = state_reg;
      addr_next      = addr_reg;
      remaining_next = remaining_reg;
      done_next      = 1'b0;
      case (state_reg)
         IDLE: begin
            if (cmd_valid) begin
               if (cmd_len == '0) begin
                  done_next = 1'b1;
               end else begin
                  addr_next      = cmd_addr;
                  remaining_next = cmd_len;
                  state_next     = READ;
               end
            end
         end
         READ: begin
            if (issue) begin
               addr_next      = addr_reg + AW'(1);
               remaining_next = remaining_reg - LENW'(1);
               if (issue_last) begin
                  state_next = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && m_last) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg         <= IDLE;
         addr_reg          <= '0;
         remaining_reg     <= '0;
         done_reg          <= 1'b0;
         inflight_reg      <= 1'b0;
         inflight_last_reg <= 1'b0;
         count_reg         <= 2'd0;
         wr_ptr_reg        <= 1'b0;
         rd_ptr_reg        <= 1'b0;
      end else begin
         state_reg         <= state_next;
         addr_reg          <= addr_next;
         remaining_reg     <= remaining_next;
         done_reg          <= done_next;
         inflight_reg      <= issue;
         inflight_last_reg <= issue_last;
         count_reg         <= count_next;
         if (push) begin
            wr_ptr_reg <= ~wr_ptr_reg;
         end
         if (pop) begin
            rd_ptr_reg <= ~rd_ptr_reg;
         end
      end
   end

   // Two-entry skid FIFO: each slot captures doutb the cycle after its read was issued.
   for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [DW-1:0] data_reg;
      logic          last_reg;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            data_reg <= '0;
            last_reg <= 1'b0;
         end else if (push && (wr_ptr_reg == 1'(gi))) begin
            data_reg <= doutb;
            last_reg <= inflight_last_reg;
         end
      end

      assign head_data[gi] = data_reg;
      assign head_last[gi] = last_reg;
   end

endmodule
